// File: rtl/blackjack_table.sv
// blackjack_table: turn-based blackjack engine for NUM_PLAYERS seats fed by
// one 16-bit LFSR card source. One FSM runs the initial deal, each seat's
// hit/stand turn in seat order, a resolve step, then holds the result.
//
// Ports:
//   clk         rising-edge clock
//   clr         synchronous active-high reset (returns to IDLE, reloads LFSR)
//   start       begin a hand; honoured only in IDLE or DONE
//   hit/stand   per-seat requests; only the active seat's bits are sampled
//   score       seat i at [i*SCORE_W +: SCORE_W], best (soft) total
//   busted      per-seat hard total > 21
//   active      seat whose turn it is (meaningful in TURN only)
//   card_valid  one-cycle pulse per dealt card, card_value 1..10 alongside
//   game_over   high while in DONE; winner mask valid with it
//   dbg_state   current FSM state encoding, for checkers and debug
//
// Handshake: hit/stand are level requests sampled every cycle with no
// acknowledge; holding hit deals one card per cycle. card_valid is a
// single-cycle pulse with no backpressure -- the consumer must take it.
module blackjack_table #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          SCORE_W     = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS-1:0]         stand,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         busted,
  output logic [2:0]                     active,
  output logic                           card_valid,
  output logic [3:0]                     card_value,
  output logic                           game_over,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic [2:0]                     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEAL    = 3'd1,
    S_TURN    = 3'd2,
    S_RESOLVE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // The start edge deals the first card, DEAL deals the remaining 2N-1 and
  // spends its final cycle handing over to TURN, so DEAL lasts 2N cycles.
  localparam logic [4:0] DEAL_LAST = 5'(2 * NUM_PLAYERS);
  localparam logic [2:0] SEAT_LAST = 3'(NUM_PLAYERS - 1);

  state_t                 state;
  logic [15:0]            lfsr;
  logic [4:0]             hard [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] has_ace;
  logic [4:0]             deal_cnt;
  logic [2:0]             deal_seat;

  logic                   fb;
  logic [7:0]             rank_m;
  logic [3:0]             draw;
  logic [4:0]             soft_v [NUM_PLAYERS];
  logic [4:0]             best;
  logic [NUM_PLAYERS-1:0] win_mask;
  logic [4:0]             cur_hard;
  logic [4:0]             new_hard;
  logic [4:0]             new_soft;
  logic                   cur_ace;
  logic                   new_ace;
  logic                   cur_hit;
  logic                   cur_stand;
  logic                   advance;

  assign dbg_state = state;

  // Card drawn from the LFSR value of the current cycle.
  always_comb begin
    fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    rank_m = lfsr[7:0] % 8'd13;               // rank - 1, 0..12
    draw   = (rank_m >= 8'd10) ? 4'd10 : rank_m[3:0] + 4'd1;
  end

  // Per-seat reported totals, bust flags and the resolve-time winner mask.
  always_comb begin
    score    = '0;
    busted   = '0;
    best     = '0;
    win_mask = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      soft_v[i] = (has_ace[i] && hard[i] <= 5'd11) ? hard[i] + 5'd10 : hard[i];
      busted[i] = hard[i] > 5'd21;
      score[i*SCORE_W +: SCORE_W] = SCORE_W'(soft_v[i]);
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!busted[i] && soft_v[i] > best) best = soft_v[i];
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      win_mask[i] = !busted[i] && (soft_v[i] == best);
    end
  end

  // Active seat's hand and requests, plus the hand it would hold after a hit.
  always_comb begin
    cur_hard  = '0;
    cur_ace   = 1'b0;
    cur_hit   = 1'b0;
    cur_stand = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (active == 3'(i)) begin
        cur_hard  = hard[i];
        cur_ace   = has_ace[i];
        cur_hit   = hit[i];
        cur_stand = stand[i];
      end
    end
    new_hard = cur_hard + {1'b0, draw};
    new_ace  = cur_ace | (draw == 4'd1);
    new_soft = (new_ace && new_hard <= 5'd11) ? new_hard + 5'd10 : new_hard;
    // Stand wins over hit; a hit that busts or lands on 21 ends the turn.
    advance  = cur_stand | (cur_hit & ((new_hard > 5'd21) | (new_soft == 5'd21)));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      active     <= '0;
      card_valid <= 1'b0;
      card_value <= '0;
      game_over  <= 1'b0;
      winner     <= '0;
      deal_cnt   <= '0;
      deal_seat  <= '0;
      has_ace    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) hard[i] <= '0;
    end else begin
      lfsr       <= {lfsr[14:0], fb};
      card_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Clear every seat, then the first card goes to seat 0 at once.
            for (int i = 0; i < NUM_PLAYERS; i++) hard[i] <= '0;
            has_ace    <= '0;
            hard[0]    <= {1'b0, draw};
            has_ace[0] <= (draw == 4'd1);
            card_valid <= 1'b1;
            card_value <= draw;
            deal_cnt   <= 5'd1;
            deal_seat  <= (SEAT_LAST == 3'd0) ? 3'd0 : 3'd1;
            game_over  <= 1'b0;
            winner     <= '0;
            active     <= '0;
            state      <= S_DEAL;
          end
        end
        S_DEAL: begin
          if (deal_cnt == DEAL_LAST) begin
            active <= '0;
            state  <= S_TURN;
          end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (deal_seat == 3'(i)) begin
                hard[i] <= hard[i] + {1'b0, draw};
                if (draw == 4'd1) has_ace[i] <= 1'b1;
              end
            end
            card_valid <= 1'b1;
            card_value <= draw;
            deal_cnt   <= deal_cnt + 5'd1;
            deal_seat  <= (deal_seat == SEAT_LAST) ? 3'd0 : deal_seat + 3'd1;
          end
        end
        S_TURN: begin
          if (cur_hit && !cur_stand) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (active == 3'(i)) begin
                hard[i]    <= new_hard;
                has_ace[i] <= new_ace;
              end
            end
            card_valid <= 1'b1;
            card_value <= draw;
          end
          if (advance) begin
            if (active == SEAT_LAST) state <= S_RESOLVE;
            else                     active <= active + 3'd1;
          end
        end
        S_RESOLVE: begin
          winner    <= win_mask;
          game_over <= 1'b1;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
